pdm_seq_ctrl: RTL and testbench
===============================

// Module: pdm_seq_ctrl
// PURPOSE
//  Sequencer driving the level-load port of the 5-bit PDM modulator core.
//  - Holds a small table of PDM levels, written over a config port.
//  - On start, presents each entry with a one-cycle write strobe, then holds it HOLD_CYCLES clocks.
//  - Plays the table once or loops; lets a waveform play back with no per-step host writes.
//  - Sits between the io_in config pins and the modulator's write_en / level inputs.
// PARAMETERS
//  LEVEL_W      5   width of a PDM level (matches modulator input)
//  DEPTH        8   table entries (power of two, 2..16)
//  HOLD_CYCLES  64  clocks between successive write strobes (>=2; one modulator period)
// PORTS
//  clk          in   1               system clock, rising edge
//  reset        in   1               asynchronous, active-high; clears all state
//  cfg_we       in   1               table write strobe
//  cfg_addr     in   $clog2(DEPTH)   table write address
//  cfg_data     in   LEVEL_W         table write data
//  len_m1       in   $clog2(DEPTH)   sequence length minus 1; sampled at start
//  start        in   1               begin playback (level-sampled, effective from IDLE only)
//  stop         in   1               abort playback
//  loop_en      in   1               wrap to entry 0 after last entry; sampled every wrap
//  pdm_level    out  LEVEL_W         level to modulator, registered
//  pdm_we       out  1               one-cycle load strobe to modulator, registered
//  busy         out  1               high while not IDLE
//  step_idx     out  $clog2(DEPTH)   index of entry currently presented
//  done         out  1               one-cycle pulse when a non-looping run completes
// BEHAVIOUR
//  Reset values: pdm_level=0, pdm_we=0, busy=0, step_idx=0, done=0, FSM=IDLE, hold counter=0.
//  Table RAM is not reset.
//  Table write: synchronous, any state. Data written to entry k during playback is used at
//  entry k's next issue.
//  FSM states:
//  - IDLE: start=1 && stop=0 at edge t -> ISSUE. len_m1 is latched into an internal length register.
//  - ISSUE, one cycle at t+1: pdm_we=1, pdm_level=table[step_idx], busy=1. Then -> HOLD.
//  - HOLD: counts HOLD_CYCLES-1 cycles with pdm_we=0 and pdm_level held.
//    - Last hold cycle, step_idx<len: step_idx+1 -> ISSUE.
//    - Last hold cycle, step_idx==len, loop_en=1: step_idx=0 -> ISSUE.
//    - Last hold cycle, step_idx==len, loop_en=0: -> IDLE, done=1 for one cycle, busy=0.
//  Strobe spacing: successive pdm_we pulses are exactly HOLD_CYCLES clocks apart, loop wrap included.
//  Single run: the first strobe is at t+1; done is asserted at t+1+(len_m1+1)*HOLD_CYCLES.
//  start while busy: ignored. stop beats start in the same cycle.
//  stop in ISSUE/HOLD: -> IDLE on the next edge; busy=0 and step_idx=0; done NOT asserted.
//    pdm_level keeps its last value unless the mute feature is compiled in.
//  len_m1 changes during playback: no effect until the next start.
//  Reset mid-run: immediate return to reset values (async). Modulator keeps its own last level.
//  Hold counter width is $clog2(HOLD_CYCLES). It never wraps outside HOLD.
// CONFIGURATION
//  PDM_SEQ_MUTE_EN
//  - Defined: stop, or normal completion with loop_en=0, first passes through a MUTE state.
//    MUTE lasts one cycle with pdm_we=1, pdm_level=0, busy=1, then -> IDLE.
//    done, for normal completion only, is pulsed on the IDLE entry cycle, i.e. 1 cycle later than undefined.
//  - Undefined: no MUTE state. The modulator keeps the last played level after the run ends.
// TESTING (bench may override HOLD_CYCLES=4 for speed; values below use the default 64)
//  1. Reset, then check reset values -> all outputs 0. Assert reset mid-HOLD -> outputs 0 the same cycle.
//  2. Write table {08,1A,0F,04}, len_m1=3, loop_en=0, start pulse at t
//     -> pdm_we at t+1, t+65, t+129, t+193 with levels 08,1A,0F,04; done at t+257; busy low after.
//  3. Same table, loop_en=1 -> 5th strobe at t+257 carries 08 with step_idx=0.
//     Clear loop_en during the 2nd pass -> done after entry 3.
//  4. stop 10 cycles after the 2nd strobe -> busy=0 next cycle, no done, no further pdm_we.
//     With PDM_SEQ_MUTE_EN: exactly one pdm_we with level 00 first.
//  5. start pulses while busy and start+stop together in IDLE -> no effect on strobe timing or state.
//  6. Rewrite entry 2 with 1F during entry 1's HOLD -> 3rd strobe carries 1F.
//     len_m1=0 -> single strobe, then done HOLD_CYCLES later.

Source files
------------

// File: rtl/pdm_seq_ctrl.sv
// Level-table sequencer feeding the PDM modulator load port (write strobe + level).
// Optional macro PDM_SEQ_MUTE_EN adds a one-cycle MUTE load of level 0 on stop/completion.
module pdm_seq_ctrl #(
   parameter int LEVEL_W     = 5,
   parameter int DEPTH       = 8,
   parameter int HOLD_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
   input  logic [LEVEL_W-1:0]         cfg_data,
   input  logic [$clog2(DEPTH)-1:0]   len_m1,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       loop_en,
   output logic [LEVEL_W-1:0]         pdm_level,
   output logic                       pdm_we,
   output logic                       busy,
   output logic [$clog2(DEPTH)-1:0]   step_idx,
   output logic                       done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 2);
   localparam logic [AW-1:0] IDX0     = '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_HOLD  = 2'd2,
      S_MUTE  = 2'd3
   } state_t;

   logic [LEVEL_W-1:0] tbl_q [DEPTH];
   state_t             state_q;
   logic [AW-1:0]      step_q;
   logic [AW-1:0]      len_q;
   logic [CW-1:0]      cnt_q;
   logic [LEVEL_W-1:0] pdm_level_q;
   logic               pdm_we_q;
   logic               busy_q;
   logic               done_q;
   logic               mute_done_q;
   logic [AW-1:0]      step_d;
   logic               abort_d;

   // Next entry index (wraps to 0 after the latched length) and abort qualifier.
   always_comb begin
      step_d  = IDX0;
      abort_d = 1'b0;
      if (step_q == len_q) begin
         step_d = IDX0;
      end else begin
         step_d = step_q + AW'(1);
      end
      if ((state_q == S_ISSUE || state_q == S_HOLD) && stop) begin
         abort_d = 1'b1;
      end else begin
         abort_d = 1'b0;
      end
   end

   // Level table: written in any state, deliberately not reset.
   always_ff @(posedge clk) begin
      if (cfg_we) begin
         tbl_q[cfg_addr] <= cfg_data;
      end
   end

   // Playback FSM with registered modulator-facing outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         step_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         pdm_level_q <= '0;
         pdm_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mute_done_q <= 1'b0;
      end else begin
         pdm_we_q <= 1'b0;
         done_q   <= 1'b0;
         if (abort_d) begin
            step_q <= '0;
            cnt_q  <= '0;
`ifdef PDM_SEQ_MUTE_EN
            state_q     <= S_MUTE;
            pdm_we_q    <= 1'b1;
            pdm_level_q <= '0;
            mute_done_q <= 1'b0;
`else
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
`endif
         end else begin
            case (state_q)
               S_IDLE: begin
                  cnt_q <= '0;
                  if (start && !stop) begin
                     state_q     <= S_ISSUE;
                     len_q       <= len_m1;
                     step_q      <= '0;
                     pdm_we_q    <= 1'b1;
                     pdm_level_q <= tbl_q[IDX0];
                     busy_q      <= 1'b1;
                  end
               end
               S_ISSUE: begin
                  state_q <= S_HOLD;
                  cnt_q   <= '0;
               end
               S_HOLD: begin
                  if (cnt_q != CNT_LAST) begin
                     cnt_q <= cnt_q + CW'(1);
                  end else if (step_q != len_q || loop_en) begin
                     // Re-issue lands exactly HOLD_CYCLES after the previous strobe.
                     state_q     <= S_ISSUE;
                     step_q      <= step_d;
                     pdm_we_q    <= 1'b1;
                     pdm_level_q <= tbl_q[step_d];
                     cnt_q       <= '0;
                  end else begin
                     step_q <= '0;
                     cnt_q  <= '0;
`ifdef PDM_SEQ_MUTE_EN
                     state_q     <= S_MUTE;
                     pdm_we_q    <= 1'b1;
                     pdm_level_q <= '0;
                     mute_done_q <= 1'b1;
`else
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
`endif
                  end
               end
               S_MUTE: begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  done_q      <= mute_done_q;
                  mute_done_q <= 1'b0;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pdm_level = pdm_level_q;
   assign pdm_we    = pdm_we_q;
   assign busy      = busy_q;
   assign step_idx  = step_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pdm_seq_ctrl.sv
// Bench for pdm_seq_ctrl (default build, HOLD_CYCLES=4): directed vector table plus
// randomized traffic checked every cycle against a schedule-based reference model.
module tb_pdm_seq_ctrl;

   localparam int LW = 5;
   localparam int D  = 8;
   localparam int H  = 4;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [LW-1:0] cfg_data;
   logic [AW-1:0] len_m1;
   logic          start;
   logic          stop;
   logic          loop_en;
   logic [LW-1:0] pdm_level;
   logic          pdm_we;
   logic          busy;
   logic [AW-1:0] step_idx;
   logic          done;

   int total = 0;
   int bad   = 0;

   pdm_seq_ctrl #(.LEVEL_W(LW), .DEPTH(D), .HOLD_CYCLES(H)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .len_m1(len_m1), .start(start), .stop(stop), .loop_en(loop_en),
      .pdm_level(pdm_level), .pdm_we(pdm_we), .busy(busy), .step_idx(step_idx), .done(done)
   );

   always #5 clk = ~clk;

   // Reference model: a run is a schedule of strobes every H cycles counted from the start edge.
   int            m_tbl [D];
   bit            m_active;
   int            m_n;
   int            m_entry;
   int            m_len;
   int            m_level;
   bit            m_we;
   bit            m_done;

   typedef struct {
      bit st; bit sp; bit lp; bit cw; int ca; int cd; int len; int n;
      int e_we; int e_lvl; int e_busy; int e_step; int e_done;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(int st, int sp, int lp, int cw, int ca, int cd, int len, int n,
                               int we, int lvl, int bz, int step, int dn);
      vec_t v;
      v.st = (st != 0); v.sp = (sp != 0); v.lp = (lp != 0); v.cw = (cw != 0);
      v.ca = ca; v.cd = cd; v.len = len; v.n = n;
      v.e_we = we; v.e_lvl = lvl; v.e_busy = bz; v.e_step = step; v.e_done = dn;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0; m_n = 0; m_entry = 0; m_level = 0; m_we = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_edge();
      m_we   = 1'b0;
      m_done = 1'b0;
      if (!m_active) begin
         if (start && !stop) begin
            m_active = 1'b1; m_n = 0; m_entry = 0; m_len = int'(len_m1);
            m_we = 1'b1; m_level = m_tbl[0];
         end
      end else begin
         m_n++;
         if (stop) begin
            m_active = 1'b0; m_entry = 0;
         end else if (m_n % H == 0) begin
            if (m_entry < m_len) begin
               m_entry++; m_we = 1'b1; m_level = m_tbl[m_entry];
            end else if (loop_en) begin
               m_entry = 0; m_we = 1'b1; m_level = m_tbl[0];
            end else begin
               m_active = 1'b0; m_entry = 0; m_done = 1'b1;
            end
         end
      end
      if (cfg_we) m_tbl[int'(cfg_addr)] = int'(cfg_data);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("pdm_we",    int'(pdm_we),    int'(m_we));
      chk("pdm_level", int'(pdm_level), m_level);
      chk("busy",      int'(busy),      int'(m_active));
      chk("step_idx",  int'(step_idx),  m_entry);
      chk("done",      int'(done),      int'(m_done));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_we"},    int'(pdm_we),    0);
      chk({tag, "_level"}, int'(pdm_level), 0);
      chk({tag, "_busy"},  int'(busy),      0);
      chk({tag, "_step"},  int'(step_idx),  0);
      chk({tag, "_done"},  int'(done),      0);
   endtask

   initial begin
      int init_tbl [D];
      init_tbl = '{'h08, 'h1A, 'h0F, 'h04, 'h11, 'h03, 'h1E, 'h00};

      // reset and reset values
      reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; len_m1 = '0;
      start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      reset = 1'b0;

      for (int i = 0; i < D; i++) begin
         cfg_we = 1'b1; cfg_addr = AW'(i); cfg_data = LW'(init_tbl[i]);
         tick();
      end
      cfg_we = 1'b0;

      // single run
      vt.push_back(mk(1,0,0,0,0,0,3,1,  1,'h08,1,0,0));
      vt.push_back(mk(0,0,0,0,0,0,3,3,  0,'h08,1,0,0));
      vt.push_back(mk(0,0,0,0,0,0,3,1,  1,'h1A,1,1,0));
      vt.push_back(mk(0,0,0,0,0,0,3,4,  1,'h0F,1,2,0));
      vt.push_back(mk(0,0,0,0,0,0,3,4,  1,'h04,1,3,0));
      vt.push_back(mk(0,0,0,0,0,0,3,3,  0,'h04,1,3,0));
      vt.push_back(mk(0,0,0,0,0,0,3,1,  0,'h04,0,0,1));
      vt.push_back(mk(0,0,0,0,0,0,3,1,  0,'h04,0,0,0));
      // loop, then clear loop_en in the second pass
      vt.push_back(mk(1,0,1,0,0,0,3,1,  1,'h08,1,0,0));
      vt.push_back(mk(0,0,1,0,0,0,3,15, 0,'h04,1,3,0));
      vt.push_back(mk(0,0,1,0,0,0,3,1,  1,'h08,1,0,0));
      vt.push_back(mk(0,0,0,0,0,0,3,4,  1,'h1A,1,1,0));
      vt.push_back(mk(0,0,0,0,0,0,3,12, 0,'h04,0,0,1));
      // stop mid-hold
      vt.push_back(mk(1,0,0,0,0,0,3,1,  1,'h08,1,0,0));
      vt.push_back(mk(0,0,0,0,0,0,3,4,  1,'h1A,1,1,0));
      vt.push_back(mk(0,0,0,0,0,0,3,2,  0,'h1A,1,1,0));
      vt.push_back(mk(0,1,0,0,0,0,3,1,  0,'h1A,0,0,0));
      vt.push_back(mk(0,0,0,0,0,0,3,8,  0,'h1A,0,0,0));
      // start+stop in idle, start held while busy, len_m1 changed mid-run
      vt.push_back(mk(1,1,0,0,0,0,3,3,  0,'h1A,0,0,0));
      vt.push_back(mk(1,0,0,0,0,0,3,1,  1,'h08,1,0,0));
      vt.push_back(mk(1,0,0,0,0,0,0,3,  0,'h08,1,0,0));
      vt.push_back(mk(1,0,0,0,0,0,0,1,  1,'h1A,1,1,0));
      vt.push_back(mk(0,0,0,0,0,0,0,12, 0,'h04,0,0,1));
      // table rewrite during playback
      vt.push_back(mk(1,0,0,0,0,0,3,1,  1,'h08,1,0,0));
      vt.push_back(mk(0,0,0,0,0,0,3,5,  0,'h1A,1,1,0));
      vt.push_back(mk(0,0,0,1,2,'h1F,3,1, 0,'h1A,1,1,0));
      vt.push_back(mk(0,0,0,0,0,0,3,2,  1,'h1F,1,2,0));
      vt.push_back(mk(0,0,0,0,0,0,3,8,  0,'h04,0,0,1));
      // len_m1 = 0
      vt.push_back(mk(1,0,0,0,0,0,0,1,  1,'h08,1,0,0));
      vt.push_back(mk(0,0,0,0,0,0,0,3,  0,'h08,1,0,0));
      vt.push_back(mk(0,0,0,0,0,0,0,1,  0,'h08,0,0,1));

      foreach (vt[i]) begin
         start = vt[i].st; stop = vt[i].sp; loop_en = vt[i].lp; cfg_we = vt[i].cw;
         cfg_addr = AW'(vt[i].ca); cfg_data = LW'(vt[i].cd); len_m1 = AW'(vt[i].len);
         for (int k = 0; k < vt[i].n; k++) tick();
         chk($sformatf("vec%0d_we", i),    int'(pdm_we),    vt[i].e_we);
         chk($sformatf("vec%0d_level", i), int'(pdm_level), vt[i].e_lvl);
         chk($sformatf("vec%0d_busy", i),  int'(busy),      vt[i].e_busy);
         chk($sformatf("vec%0d_step", i),  int'(step_idx),  vt[i].e_step);
         chk($sformatf("vec%0d_done", i),  int'(done),      vt[i].e_done);
      end
      cfg_we = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; len_m1 = AW'(3);

      // asynchronous reset in the middle of a hold
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk_zero("midrst");
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         start    = ($urandom_range(7) == 0);
         stop     = ($urandom_range(40) == 0);
         if ($urandom_range(15) == 0) loop_en = ~loop_en;
         cfg_we   = ($urandom_range(5) == 0);
         cfg_addr = AW'($urandom_range(D - 1));
         cfg_data = LW'($urandom_range(31));
         len_m1   = AW'($urandom_range(D - 1));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
